// File: rtl/shift_reg_univ.sv
// Universal shift register: DEPTH stages of LANE bits with bidirectional shift, parallel load,
// hold, and a saturating shift counter with frame-complete pulse. Define SHREG_ROTATE_EN to add rotate.
module shift_reg_univ #(
  parameter  int LANE  = 1,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [LANE-1:0]       sin_lo,
  input  logic [LANE-1:0]       sin_hi,
  input  logic [LANE*DEPTH-1:0] pin,
  output logic [LANE*DEPTH-1:0] pout,
  output logic [LANE-1:0]       so,
  output logic [CNT_W-1:0]      shift_cnt,
`ifdef SHREG_ROTATE_EN
  output logic                  frame_done,
  input  logic                  rotate
`else
  output logic                  frame_done
`endif
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [DEPTH-1:0][LANE-1:0] stage_q, stage_d;
  logic [LANE-1:0]            so_q, so_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       done_q, done_d;
  logic                       rot_w;
  logic                       shift_w;
  mode_e                      mode_w;

  assign mode_w = mode_e'(mode);

`ifdef SHREG_ROTATE_EN
  assign rot_w = rotate;
`else
  assign rot_w = 1'b0;
`endif

  always_comb begin
    stage_d = stage_q;
    so_d    = so_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    shift_w = 1'b0;
    if (en) begin
      unique case (mode_w)
        MODE_HOLD: ;
        MODE_UP: begin
          shift_w = 1'b1;
          so_d    = stage_q[DEPTH-1];
          for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
          end
          stage_d[0] = rot_w ? stage_q[DEPTH-1] : sin_lo;
        end
        MODE_DOWN: begin
          shift_w = 1'b1;
          so_d    = stage_q[0];
          for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            stage_d[i] = stage_q[i+1];
          end
          stage_d[DEPTH-1] = rot_w ? stage_q[0] : sin_hi;
        end
        MODE_LOAD: begin
          stage_d = pin;
          cnt_d   = '0;
        end
      endcase
    end
    // The pulse fires only on the DEPTH-1 -> DEPTH step, so saturation suppresses re-pulsing.
    if (shift_w && (cnt_q != CNT_MAX)) begin
      cnt_d  = cnt_q + CNT_W'(1);
      done_d = (cnt_q == CNT_MAX - CNT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      so_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      so_q    <= so_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign pout       = stage_q;
  assign so         = so_q;
  assign shift_cnt  = cnt_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: two instances (LANE=1/DEPTH=4 and LANE=8/DEPTH=3) against a queue-based model.
module tb_shift_reg_univ;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_en, a_rot, a_done;
  logic [1:0]  a_mode;
  logic [0:0]  a_slo, a_shi, a_so;
  logic [3:0]  a_pin, a_pout;
  logic [2:0]  a_cnt;

  logic        b_en, b_rot, b_done;
  logic [1:0]  b_mode;
  logic [7:0]  b_slo, b_shi, b_so;
  logic [23:0] b_pin, b_pout;
  logic [1:0]  b_cnt;

  shift_reg_univ #(.LANE(1), .DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .en(a_en), .mode(a_mode),
    .sin_lo(a_slo), .sin_hi(a_shi), .pin(a_pin), .pout(a_pout),
    .so(a_so), .shift_cnt(a_cnt), .frame_done(a_done)
`ifdef SHREG_ROTATE_EN
    , .rotate(a_rot)
`endif
  );

  shift_reg_univ #(.LANE(8), .DEPTH(3)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .mode(b_mode),
    .sin_lo(b_slo), .sin_hi(b_shi), .pin(b_pin), .pout(b_pout),
    .so(b_so), .shift_cnt(b_cnt), .frame_done(b_done)
`ifdef SHREG_ROTATE_EN
    , .rotate(b_rot)
`endif
  );

  // Model state per instance: stage symbols, serial out, shift count, pending pulse.
  int st[2][8];
  int m_so[2], m_cnt[2], m_done[2];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_pout(input int k, input int depth, input int lane);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < depth; i++) r = r | (64'(st[k][i]) << (i * lane));
    return r;
  endfunction

  task automatic mstep(input int k, input int depth, input int lane, input logic en,
                       input logic [1:0] md, input int slo, input int shi,
                       input logic [63:0] pin, input logic rot);
    int q[$];
    int out;
    logic [63:0] mask;
    m_done[k] = 0;
    if (!en || md == 2'b00) return;
    if (md == 2'b11) begin
      mask = (64'd1 << lane) - 64'd1;
      for (int i = 0; i < depth; i++) st[k][i] = int'((pin >> (i * lane)) & mask);
      m_cnt[k] = 0;
      return;
    end
    for (int i = 0; i < depth; i++) q.push_back(st[k][i]);
    if (md == 2'b01) begin
      out = q.pop_back();
      q.push_front(rot ? out : slo);
    end else begin
      out = q.pop_front();
      q.push_back(rot ? out : shi);
    end
    for (int i = 0; i < depth; i++) st[k][i] = q[i];
    m_so[k] = out;
    if (m_cnt[k] == depth - 1) m_done[k] = 1;
    if (m_cnt[k] < depth) m_cnt[k]++;
  endtask

  task automatic check_all();
    chk("a_pout", 64'(a_pout), exp_pout(0, 4, 1));
    chk("a_so",   64'(a_so),   64'(m_so[0]));
    chk("a_cnt",  64'(a_cnt),  64'(m_cnt[0]));
    chk("a_done", 64'(a_done), 64'(m_done[0]));
    chk("b_pout", 64'(b_pout), exp_pout(1, 3, 8));
    chk("b_so",   64'(b_so),   64'(m_so[1]));
    chk("b_cnt",  64'(b_cnt),  64'(m_cnt[1]));
    chk("b_done", 64'(b_done), 64'(m_done[1]));
  endtask

  task automatic step();
    mstep(0, 4, 1, a_en, a_mode, int'(a_slo), int'(a_shi), 64'(a_pin), a_rot);
    mstep(1, 3, 8, b_en, b_mode, int'(b_slo), int'(b_shi), 64'(b_pin), b_rot);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset is observed between clock edges, before any edge could register it.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) st[k][i] = 0;
      m_so[k] = 0; m_cnt[k] = 0; m_done[k] = 0;
    end
    check_all();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int t2a[8];
    logic [7:0] t2b[6];
    int r;
    t2a = '{1, 1, 0, 1, 0, 0, 0, 0};
    t2b = '{8'hA5, 8'h3C, 8'hF0, 8'h00, 8'h00, 8'h00};
    a_en = 1'b0; a_mode = 2'b00; a_slo = '0; a_shi = '0; a_pin = '0; a_rot = 1'b0;
    b_en = 1'b0; b_mode = 2'b00; b_slo = '0; b_shi = '0; b_pin = '0; b_rot = 1'b0;

    #1;
    async_reset();

    // Shift up a known pattern, then flush it out to so.
    a_en = 1'b1; a_mode = 2'b01;
    b_mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      a_slo = 1'(t2a[i]);
      b_en  = (i < 6);
      b_slo = t2b[i % 6];
      step();
      if (i == 3) chk("t2_pout_1101", 64'(a_pout), 64'h0D);
    end
    b_en = 1'b0;

    // Load then shift down with zero fill.
    a_mode = 2'b11; a_pin = 4'b1010;
    step();
    chk("t3_cnt_after_load", 64'(a_cnt), 64'd0);
    a_mode = 2'b10; a_shi = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t3_pout_zero", 64'(a_pout), 64'd0);

    // Hold by mode, then hold by enable.
    a_mode = 2'b00;
    for (int i = 0; i < 3; i++) step();
    a_en = 1'b0; a_mode = 2'b01; a_slo = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Reset mid-frame, then a full frame.
    a_en = 1'b1;
    for (int i = 0; i < 2; i++) step();
    async_reset();
    for (int i = 0; i < 4; i++) step();

`ifdef SHREG_ROTATE_EN
    a_mode = 2'b11; a_pin = 4'b1000; a_rot = 1'b1;
    step();
    a_mode = 2'b01;
    for (int i = 0; i < 4; i++) step();
    a_rot = 1'b0;
`endif

    // Randomized traffic on both instances with occasional asynchronous reset.
    for (int n = 0; n < 300; n++) begin
      a_en  = ($urandom_range(0, 7) != 0);
      r     = int'($urandom_range(0, 9));
      a_mode = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : (r < 6) ? 2'b01 : 2'b10;
      a_slo = 1'($urandom); a_shi = 1'($urandom); a_pin = 4'($urandom);
      b_en  = ($urandom_range(0, 7) != 0);
      r     = int'($urandom_range(0, 9));
      b_mode = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : (r < 6) ? 2'b01 : 2'b10;
      b_slo = 8'($urandom); b_shi = 8'($urandom); b_pin = 24'($urandom);
`ifdef SHREG_ROTATE_EN
      a_rot = 1'($urandom); b_rot = 1'($urandom);
`endif
      if ($urandom_range(0, 49) == 0) async_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
Parametrised universal shift register; successor to the 4-bit serial-in/serial-out register.
- Generalised to DEPTH stages of LANE bits each.
- Adds bidirectional shift, parallel load/read, hold, and a shift counter with a frame-complete pulse.
- Used as the serialiser/deserialiser building block in the regs library.

Parameters:
LANE, 1, bits per stage; one shift moves one LANE-bit symbol.
DEPTH, 4, number of stages; DEPTH >= 2.
CNT_W, $clog2(DEPTH+1), shift counter width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  operation enable; 0 = hold everything
mode  in  2  00 hold, 01 shift up (toward MSB stage), 10 shift down (toward LSB stage), 11 parallel load
sin_lo  in  LANE  serial input entering stage 0 on shift up
sin_hi  in  LANE  serial input entering stage DEPTH-1 on shift down
pin  in  LANE*DEPTH  parallel load data; stage i = pin[i*LANE +: LANE]
pout  out  LANE*DEPTH  current register contents, same packing as pin
so  out  LANE  registered serial output: stage shifted out on the last shift
shift_cnt  out  CNT_W  shifts since last load/reset, saturating at DEPTH
frame_done  out  1  one-cycle pulse when shift_cnt reaches DEPTH
rotate  in  1  present only with SHREG_ROTATE_EN (see Optional Feature)

Behaviour:
- Reset (async, any time, including mid-operation): stages = 0, so = 0, shift_cnt = 0, frame_done = 0. All outputs are registered.
- en=0 or mode=00: stages, so and shift_cnt hold; frame_done = 0.
- Shift up (en=1, mode=01), one edge:
  - so <= stage[DEPTH-1]
  - stage[i] <= stage[i-1]
  - stage[0] <= sin_lo
- Shift down (en=1, mode=10), one edge:
  - so <= stage[0]
  - stage[i] <= stage[i+1]
  - stage[DEPTH-1] <= sin_hi
- Parallel load (en=1, mode=11): stages <= pin; shift_cnt <= 0; so holds; frame_done = 0.
- Latency: a symbol presented on sin_lo appears on so DEPTH+1 edges later under continuous shift up. Shift down is symmetric.
- shift_cnt:
  - Increments by 1 on every shift (either direction) while below DEPTH.
  - Saturates at DEPTH; further shifts leave it at DEPTH.
- frame_done:
  - Asserted for exactly the cycle after the edge on which shift_cnt goes DEPTH-1 -> DEPTH.
  - Does not re-pulse while saturated.
  - Re-arms only after a load or reset.
- Direction change mid-frame is legal. The counter counts total shifts regardless of direction.
- Mode encodings are exhaustive; there is no illegal state.

Optional Feature:
Macro SHREG_ROTATE_EN.
- Defined:
  - Input port rotate is present.
  - When rotate=1 during a shift, the outgoing stage re-enters at the opposite end instead of sin_lo/sin_hi.
  - so and shift_cnt behave as for a normal shift.
  - rotate is ignored for hold and load.
- Undefined:
  - Port is absent.
  - Shifts always take serial inputs.

Test Plan:
Unless noted, LANE=1, DEPTH=4.
1. Reset: assert rst between edges -> pout=0000, so=0, shift_cnt=0, frame_done=0 immediately, without waiting for clk.
2. Shift up, sin_lo = 1,1,0,1 over 4 edges:
   - pout=1101 (stage3..0); so=0 each edge.
   - shift_cnt goes 1,2,3,4; frame_done=1 only in the cycle after the 4th edge.
   - Then 4 more shifts with sin_lo=0 -> so = 1,1,0,1; no second frame_done pulse.
3. Load pin=1010, then shift down with sin_hi=0:
   - shift_cnt=0 after the load.
   - so = 0,1,0,1 over 4 edges; pout ends 0000; frame_done pulses after the 4th shift.
4. Hold: mode=00 for 3 cycles, then en=0 with mode=01 for 3 cycles -> pout, so and shift_cnt unchanged; frame_done=0.
5. Reset mid-frame: 2 shifts, then rst pulse -> all outputs 0; no frame_done; next 4 shifts produce a frame_done pulse.
6. With SHREG_ROTATE_EN: load 1000, rotate=1, shift up 4 times -> pout = 0001, 0010, 0100, 1000; so = 1,0,0,0; frame_done after the 4th edge. Also repeat test 2 with LANE=8, DEPTH=3 to confirm per-symbol packing.
